// File: rtl/mp1_mem_model.sv
// Word-addressed behavioural memory with a fixed response latency.
// Includes sticky protocol error reporting and a completed-transaction counter.
module mp1_mem_model #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [1:0]  errcode,
  output logic [31:0] txn_count
);

  // state | meaning
  // IDLE  | waiting for exactly one of mem_read / mem_write
  // WAIT  | request latched, counting down the latency, watching for aborts
  // RESP  | mem_resp high for one cycle; a write commits at the end of it
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [31:0]       r_mem [2**ADDR_W];
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_rdata;
  logic              r_resp;
  logic [1:0]        r_err;
  logic [31:0]       r_txn;

  logic              w_both;
  logic              w_one;
  logic              w_active;
  logic              w_abort;
  logic [ADDR_W-1:0] w_idx;

  assign w_both   = mem_read & mem_write;
  assign w_one    = mem_read ^ mem_write;
  assign w_active = r_is_write ? mem_write : mem_read;
  assign w_abort  = !w_active || (mem_address != r_addr);
  assign w_idx    = mem_address[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_rdata    <= 32'd0;
      r_resp     <= 1'b0;
      r_err      <= 2'd0;
      r_txn      <= 32'd0;
    end else begin
      r_resp <= 1'b0;
      if (w_both && r_err == 2'd0) r_err <= 2'd1;
      case (r_state)
        IDLE: begin
          if (w_one) begin
            r_is_write <= mem_write;
            r_idx      <= w_idx;
            r_addr     <= mem_address;
            r_wdata    <= mem_wdata;
            r_be       <= mem_byte_enable;
            r_cnt      <= CNT_LOAD;
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_resp  <= 1'b1;
              r_txn   <= r_txn + 32'd1;
              if (mem_read) r_rdata <= r_mem[w_idx];
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A simultaneous read+write already claims error code 1 above
          if (w_abort) begin
            r_state <= IDLE;
            if (r_err == 2'd0 && !w_both) r_err <= 2'd2;
          end else if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
            r_txn   <= r_txn + 32'd1;
            if (!r_is_write) r_rdata <= r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; a reset during RESP drops the write
  always_ff @(posedge clk) begin
    if (rst && r_state == RESP && r_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = r_resp;
  assign errcode   = r_err;
  assign txn_count = r_txn;

endmodule

// File: tb/tb_mp1_mem_model.sv
// Bench for mp1_mem_model: vector table of transactions plus hand-written
// sequences for protocol errors, aborts and reset during a transfer.
module tb_mp1_mem_model;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'd0;
  logic [31:0] mem_address = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [1:0]  errcode;
  logic [31:0] txn_count;

  mp1_mem_model #(.LATENCY(LAT), .ADDR_W(10)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .errcode         (errcode),
    .txn_count       (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[11];
  sb_t  sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the request until mem_resp (bounded), then check latency and data.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata, input string name);
    int  cyc;
    bit  got;
    sb_t e;
    sb_q.push_back('{rd: !wr, exp: exp_rdata});
    mem_read        = !wr;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    tick();
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      if (mem_resp) got = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    chk({name, "_latency"}, 32'(cyc), 32'(LAT - 1));
    e = sb_q.pop_front();
    if (e.rd) chk({name, "_rdata"}, mem_rdata, e.exp);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = 32'hFFFF_FFFF;
    mem_byte_enable = 4'hF;
    tick();
    chk({name, "_pulse_end"}, {31'd0, mem_resp}, 32'd0);
    if (e.rd) chk({name, "_rdata_hold"}, mem_rdata, e.exp);
  endtask

  initial begin
    bit          any_resp;
    logic [31:0] txn_before;
    sb_t         e;

    vecs[0]  = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr_104"};
    vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'hDEAD_BEEF, "rd_104"};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 32'h0, "wr_8_init"};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 32'h0, "wr_8_lanes"};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h11BB_33DD, "rd_8"};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 4'hF, 32'h0, "wr_alias"};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h5A5A_5A5A, "rd_alias"};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h0102_0304, 4'hF, 32'h0, "wr_10"};
    vecs[8]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h0, 32'h0, "wr_10_nomask"};
    vecs[9]  = '{1'b1, 32'h0000_0013, 32'h0000_FFFF, 4'hC, 32'h0, "wr_13_hi"};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0000_0304, "rd_10"};

    // Reset state
    repeat (3) tick();
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_err", {30'd0, errcode}, 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp, vecs[i].name);
      if (i == 1) chk("txn_after_two", txn_count, 32'd2);
    end
    chk("txn_after_table", txn_count, 32'd11);
    chk("err_clean", {30'd0, errcode}, 32'd0);

    // Read and write together: no acceptance, errcode 1, later abort keeps 1
    txn_before = txn_count;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h104;
    tick();
    chk("both_resp", {31'd0, mem_resp}, 32'd0);
    chk("both_err", {30'd0, errcode}, 32'd1);
    mem_write = 1'b0;
    tick();
    mem_address = 32'h108;
    tick();
    mem_read = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_resp) any_resp = 1'b1;
      tick();
    end
    chk("both_abort_noresp", {31'd0, any_resp}, 32'd0);
    chk("both_abort_err", {30'd0, errcode}, 32'd1);
    chk("both_abort_txn", txn_count, txn_before);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("err_cleared", {30'd0, errcode}, 32'd0);

    // Write dropped one cycle after acceptance
    mem_write = 1'b1; mem_address = 32'h104; mem_wdata = 32'h1234_5678; mem_byte_enable = 4'hF;
    tick();
    mem_write = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_resp) any_resp = 1'b1;
    end
    chk("drop_noresp", {31'd0, any_resp}, 32'd0);
    chk("drop_err", {30'd0, errcode}, 32'd2);
    txn(1'b0, 32'h104, 32'h0, 4'h0, 32'hDEAD_BEEF, "drop_rd_unchanged");
    chk("drop_err_sticky", {30'd0, errcode}, 32'd2);

    // Reset while a read is waiting
    sb_q.push_back('{rd: 1'b1, exp: 32'h11BB_33DD});
    mem_read = 1'b1; mem_address = 32'h8;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_rdata", mem_rdata, 32'd0);
    chk("rst_mid_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_mid_err", {30'd0, errcode}, 32'd0);
    chk("rst_mid_txn", txn_count, 32'd0);
    any_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_resp) any_resp = 1'b1;
    end
    chk("rst_held_noresp", {31'd0, any_resp}, 32'd0);
    e = sb_q.pop_front();
    rst = 1'b1;
    txn(1'b0, 32'h8, 32'h0, 4'h0, e.exp, "rd_after_rst");
    chk("txn_after_rst", txn_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
